id_scoreboard: RTL and testbench
================================

# id_scoreboard

Pending-write scoreboard in the ID stage, alongside the register file. Tracks, per architectural register R0–R14, how many issued instructions still owe a write-back. It raises a combinational `hazard` that stalls the instruction currently in ID until its sources are safe to read. It consumes the same retire signals (`wb_en`/`wb_dst`) that drive the register file's write port.

## Interface
Parameters:
- `NREG`, 15: tracked registers (R0..R14); R15/PC is never tracked.
- `CW`, 2: per-register counter width; holds up to 3 in-flight writers (EX, MEM, WB).

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: a real instruction occupies ID this cycle.
- `src1`, `src2` in 4: source register numbers.
- `src1_used`, `src2_used` in 1: the corresponding source is actually read.
- `id_wb_en` in 1: the ID instruction will write a register.
- `id_dst` in 4: its destination.
- `freeze` in 1: memory stall; blocks issue.
- `flush` in 1: taken branch in EX; the ID instruction is squashed.
- `wb_en` in 1: retire strobe, one pulse per writing instruction.
- `wb_dst` in 4: retiring destination.
- `hazard` out 1: stall IF/ID this cycle.
- `issue` out 1: ID instruction accepted into EX this cycle.
- `busy_map` out NREG: bit i set when count[i] != 0.
- `overflow_err`, `underflow_err` out 1: sticky error flags (see Configuration).

## Operation
- State: `count[0..14]`, each CW bits.
- `busy_eff(r)` = (r != 15) and count[r] != 0, excluding the case count[r]==1 and wb_en and wb_dst==r.
  - The register file writes on negedge, so a value retiring this cycle is readable by ID in the same cycle.
- `hazard` = id_valid & !flush & ((src1_used & busy_eff(src1)) | (src2_used & busy_eff(src2))).
- `issue` = id_valid & !hazard & !freeze & !flush.
- Posedge update for register r:
  - `inc` = issue & id_wb_en & id_dst==r & r!=15.
  - `dec` = wb_en & wb_dst==r & r!=15.
  - inc & !dec: count+1. dec & !inc: count−1. Both asserted, or neither: count unchanged.
- Counter boundaries:
  - inc at count==3 (max): count holds at 3 and `overflow_err` is set.
  - dec at count==0: count holds at 0 and `underflow_err` is set.
- Destination or source 15 never touches a counter and never creates a hazard.
- WAW needs no special handling; the counter absorbs repeated writers to the same register.
- `flush` drops the ID instruction only. Counts for instructions already in EX/MEM/WB are kept; they still retire.

## Timing
- Reset (async): all counts 0, `busy_map`=0, error flags 0. As a result `hazard`=0 and `issue`=id_valid & !freeze & !flush.
- Reset asserted mid-operation clears all counts immediately, regardless of `clk`.
- `hazard`, `issue`: combinational, same cycle as their inputs.
- An issue at posedge k makes `busy_map` show the register from just after posedge k.
  - A dependent instruction in ID during cycle k+1 therefore sees `hazard`=1.
- A retire in cycle n: `hazard` drops within cycle n through the bypass term; `busy_map` clears after posedge n.
- Simultaneous issue and retire of the same register in one cycle: count unchanged, `busy_map` bit stays set.
- `freeze` with `wb_en` in the same cycle: the retire is applied and the issue is blocked.

## Configuration
- `SCOREBOARD_ERR_EN` defined:
  - `overflow_err`/`underflow_err` are sticky registers, cleared only by `rst`.
  - The counter saturation/floor described above is implemented with the error flags.
- `SCOREBOARD_ERR_EN` undefined:
  - Both flags are tied to 0.
  - Counters still saturate and floor silently; no extra flops.

## Test plan
- Reset mid-run with counts R3=2, R7=1 → busy_map=0 immediately, hazard=0; id_valid=1 with no freeze/flush gives issue=1.
- Issue ADD R2 at posedge k; next cycle ID reads R2 (src1_used=1) → hazard=1, issue=0; hold until the cycle wb_en=1, wb_dst=2 → hazard=0 in that cycle, issue=1.
- Issue two writers to R5 back-to-back, then one retire → busy_map[5] remains 1 until the second retire, then 0.
- Same cycle: issue with id_dst=4 and wb_en, wb_dst=4, count[4]=1 → count stays 1, busy_map[4]=1.
- id_dst=15 and src1=15 → no counter change, hazard=0. flush=1 with a pending source hazard → hazard=0, issue=0, counts unchanged.
- With SCOREBOARD_ERR_EN: wb_en with wb_dst=9, count 0 → underflow_err=1 and stays 1 until rst. Without the macro → flag stays 0, count stays 0.

Source files
------------

// File: rtl/id_scoreboard_if.sv
// ID-stage scoreboard bus: issue-side request, retire strobe, and the hazard/issue/busy results.
// The pipeline side drives through master; the scoreboard sits on slave.
interface id_scoreboard_if #(
  parameter int NREG = 15
);
  logic            id_valid;
  logic [3:0]      src1;
  logic [3:0]      src2;
  logic            src1_used;
  logic            src2_used;
  logic            id_wb_en;
  logic [3:0]      id_dst;
  logic            freeze;
  logic            flush;
  logic            wb_en;
  logic [3:0]      wb_dst;
  logic            hazard;
  logic            issue;
  logic [NREG-1:0] busy_map;
  logic            overflow_err;
  logic            underflow_err;

  modport master (
    output id_valid, src1, src2, src1_used, src2_used, id_wb_en, id_dst,
           freeze, flush, wb_en, wb_dst,
    input  hazard, issue, busy_map, overflow_err, underflow_err
  );

  modport slave (
    input  id_valid, src1, src2, src1_used, src2_used, id_wb_en, id_dst,
           freeze, flush, wb_en, wb_dst,
    output hazard, issue, busy_map, overflow_err, underflow_err
  );
endinterface

// File: rtl/id_scoreboard.sv
// Pending-write scoreboard for R0..R14: per-register in-flight writer counters with retire bypass.
// Define SCOREBOARD_ERR_EN to get sticky overflow/underflow flags; otherwise they read 0.
module id_scoreboard #(
  parameter int NREG = 15,
  parameter int CW   = 2
) (
  input  logic           clk,
  input  logic           rst,
  id_scoreboard_if.slave bus
);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] count_q [NREG];
  logic [CW-1:0] count_d [NREG];

  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] sat_hit;
  logic [NREG-1:0] floor_hit;
  logic [15:0]     busy_pad;
  logic            src1_busy;
  logic            src2_busy;
  logic            hazard;
  logic            issue;

  // R15 lives in the top pad bit and is therefore never busy.
  always_comb begin
    busy_pad             = '0;
    busy_pad[NREG-1:0]   = busy_eff;
  end

  always_comb begin
    src1_busy = bus.src1_used & busy_pad[bus.src1];
    src2_busy = bus.src2_used & busy_pad[bus.src2];
    hazard    = bus.id_valid & ~bus.flush & (src1_busy | src2_busy);
    issue     = bus.id_valid & ~hazard & ~bus.freeze & ~bus.flush;
  end

  assign bus.hazard = hazard;
  assign bus.issue  = issue;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      localparam logic [3:0] REG_ID = 4'(gi);

      logic inc;
      logic dec;
      logic at_max;
      logic at_zero;

      assign inc     = issue & bus.id_wb_en & (bus.id_dst == REG_ID);
      assign dec     = bus.wb_en & (bus.wb_dst == REG_ID);
      assign at_max  = (count_q[gi] == CNT_MAX);
      assign at_zero = (count_q[gi] == CNT_ZERO);

      // A last writer retiring this cycle is already visible through the negedge register-file write.
      assign busy_eff[gi]     = ~at_zero & ~((count_q[gi] == CNT_ONE) & dec);
      assign sat_hit[gi]      = inc & ~dec & at_max;
      assign floor_hit[gi]    = dec & ~inc & at_zero;
      assign bus.busy_map[gi] = ~at_zero;

      always_comb begin
        count_d[gi] = count_q[gi];
        if (inc && !dec && !at_max) begin
          count_d[gi] = count_q[gi] + CNT_ONE;
        end else if (dec && !inc && !at_zero) begin
          count_d[gi] = count_q[gi] - CNT_ONE;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_q[gi] <= '0;
        end else begin
          count_q[gi] <= count_d[gi];
        end
      end
    end
  endgenerate

`ifdef SCOREBOARD_ERR_EN
  logic overflow_q;
  logic overflow_d;
  logic underflow_q;
  logic underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (|sat_hit);
    underflow_d = underflow_q | (|floor_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow_err  = overflow_q;
  assign bus.underflow_err = underflow_q;
`else
  // Saturation and floor still apply in the counters; only the reporting is dropped.
  logic unused_err;
  assign unused_err        = (|sat_hit) | (|floor_hit);
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Randomized bench for id_scoreboard against an array-of-counts reference model.
// Honours SCOREBOARD_ERR_EN the same way the design does when predicting the error flags.
module tb_id_scoreboard;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_scoreboard_if #(.NREG(15)) bus ();

  id_scoreboard #(.NREG(15), .CW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cnt [15];
  bit m_ovf;
  bit m_unf;
  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    if (r == 15) return 1'b0;
    if (cnt[r] == 0) return 1'b0;
    if (cnt[r] == 1 && bus.wb_en && int'(bus.wb_dst) == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [14:0] m_map();
    logic [14:0] m;
    for (int r = 0; r < 15; r++) m[r] = (cnt[r] != 0);
    return m;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 15; r++) cnt[r] = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Drive one cycle of ID/WB inputs, check comb outputs and state, then advance the model at posedge.
  task automatic step(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                      input bit we, input int d, input bit frz, input bit fl,
                      input bit wbe, input int wbd);
    bit e_haz, e_iss, inc, dec;
    @(negedge clk);
    bus.id_valid = v;  bus.src1 = 4'(s1); bus.src2 = 4'(s2);
    bus.src1_used = u1; bus.src2_used = u2;
    bus.id_wb_en = we; bus.id_dst = 4'(d);
    bus.freeze = frz; bus.flush = fl;
    bus.wb_en = wbe; bus.wb_dst = 4'(wbd);
    #1;
    e_haz = v && !fl && ((u1 && m_busy(s1)) || (u2 && m_busy(s2)));
    e_iss = v && !e_haz && !frz && !fl;
    check("hazard", 32'(bus.hazard), 32'(e_haz));
    check("issue", 32'(bus.issue), 32'(e_iss));
    check("busy_map", 32'(bus.busy_map), 32'(m_map()));
`ifdef SCOREBOARD_ERR_EN
    check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
    check("underflow_err", 32'(bus.underflow_err), 32'(m_unf));
`else
    check("overflow_err", 32'(bus.overflow_err), 32'd0);
    check("underflow_err", 32'(bus.underflow_err), 32'd0);
`endif
    @(posedge clk);
    for (int r = 0; r < 15; r++) begin
      inc = e_iss && we && d == r;
      dec = wbe && wbd == r;
      if (inc && !dec) begin
        if (cnt[r] == 3) m_ovf = 1'b1;
        else cnt[r] = cnt[r] + 1;
      end else if (dec && !inc) begin
        if (cnt[r] == 0) m_unf = 1'b1;
        else cnt[r] = cnt[r] - 1;
      end
    end
  endtask

  task automatic idle(input bit wbe, input int wbd);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, wbe, wbd);
  endtask

  task automatic random_step();
    int busy_list[$];
    int wbd;
    bit wbe;
    for (int r = 0; r < 15; r++) if (cnt[r] != 0) busy_list.push_back(r);
    wbe = ($urandom_range(0, 99) < 40);
    if (busy_list.size() != 0 && $urandom_range(0, 99) < 90)
      wbd = busy_list[$urandom_range(0, busy_list.size() - 1)];
    else
      wbd = $urandom_range(0, 15);
    step($urandom_range(0, 99) < 80, $urandom_range(0, 15), $urandom_range(0, 15),
         $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 99) < 70,
         $urandom_range(0, 15), $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
         wbe, wbd);
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    bus.id_valid = 0; bus.src1 = 0; bus.src2 = 0; bus.src1_used = 0; bus.src2_used = 0;
    bus.id_wb_en = 0; bus.id_dst = 0; bus.freeze = 0; bus.flush = 0;
    bus.wb_en = 0; bus.wb_dst = 0;
    #1;
    check("reset_busy_map", 32'(bus.busy_map), 32'd0);
    check("reset_hazard", 32'(bus.hazard), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // RAW on R2: writer issues, reader stalls until the retire cycle bypasses it.
    step(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 1, 0, 1, 8, 0, 0, 0, 0);
    step(1, 2, 0, 1, 0, 1, 8, 0, 0, 0, 0);
    step(1, 2, 0, 1, 0, 1, 8, 0, 0, 1, 2);
    idle(1, 8);

    // Two writers to R5, then retire one at a time.
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0);
    idle(1, 5);
    idle(0, 0);
    idle(1, 5);
    idle(0, 0);

    // Simultaneous issue and retire of R4 with one writer pending.
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 4);
    idle(0, 0);
    idle(1, 4);

    // R15 is never tracked; flush squashes a hazarded instruction without touching counts.
    step(1, 15, 15, 1, 1, 1, 15, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 1, 7, 0, 1, 0, 0);
    // Freeze blocks issue while the retire still lands.
    step(1, 0, 0, 0, 0, 1, 7, 1, 0, 1, 6);
    idle(0, 0);

    // Saturation at 3 writers, then underflow on an idle register.
    repeat (4) step(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 0);
    idle(1, 9);
    idle(0, 0);
    repeat (3) idle(1, 11);
    idle(0, 0);

    // Reset mid-run with R3=2, R7=1.
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
    @(negedge clk);
    bus.id_valid = 1; bus.src1 = 4'd3; bus.src1_used = 1; bus.src2_used = 0;
    bus.id_wb_en = 0; bus.freeze = 0; bus.flush = 0; bus.wb_en = 0;
    #1;
    check("pre_rst_hazard", 32'(bus.hazard), 32'd1);
    #1 rst = 1'b1;
    #1;
    clear_model();
    check("rst_busy_map", 32'(bus.busy_map), 32'd0);
    check("rst_hazard", 32'(bus.hazard), 32'd0);
    check("rst_issue", 32'(bus.issue), 32'd1);
    check("rst_underflow_err", 32'(bus.underflow_err), 32'd0);
    #1 rst = 1'b0;

    repeat (2000) random_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
